// File: rtl/exec_ctrl.sv
// rtl/exec_ctrl.sv - execute-stage controller: regfile, ALU drive, writeback and branch redirect
module exec_ctrl #(
    parameter int NREGS = 8,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    input  logic [WIDTH-1:0] instr_pc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_positive,
    output logic             flag_z,
    output logic             flag_p,
    output logic             wb_valid,
    output logic [2:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_COMMIT
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] regs [NREGS];
    logic [15:0]      instr_q;
    logic [WIDTH-1:0] pc_q;
    logic             alu_z_q, alu_p_q, upd_flags_q;

    logic [3:0]       op;
    logic [2:0]       rd, rs;
    logic [WIDTH-1:0] imm9_sx, imm6_sx;
    logic             do_wb, do_redirect, upd_flags;
    logic [WIDTH-1:0] wb_value;

    assign op      = instr_q[15:12];
    assign rd      = instr_q[11:9];
    assign rs      = instr_q[8:6];
    assign imm9_sx = {{(WIDTH-9){instr_q[8]}}, instr_q[8:0]};
    assign imm6_sx = {{(WIDTH-6){instr_q[5]}}, instr_q[5:0]};

    assign instr_ready = (state == S_IDLE) && !rst;

    always_comb begin
        state_n     = state;
        alu_a       = '0;
        alu_b       = '0;
        alu_opcode  = 4'b0000;
        do_wb       = 1'b0;
        wb_value    = '0;
        upd_flags   = 1'b0;
        do_redirect = 1'b0;
        case (state)
            S_IDLE:   if (instr_valid && instr_ready) state_n = S_EXEC;
            S_EXEC:   state_n = S_COMMIT;
            S_COMMIT: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        if (state == S_EXEC) begin
            casez (op)
                4'b1???: begin
                    alu_opcode = op;
                    alu_a      = regs[rs];
                    alu_b      = regs[rd];
                    do_wb      = 1'b1;
                    wb_value   = alu_result;
                    upd_flags  = 1'b1;
                end
                4'b0101: begin
                    alu_opcode = op;
                    alu_a      = regs[rs];
                    alu_b      = regs[rd];
                    do_wb      = 1'b1;
                    wb_value   = ~regs[rd];
                    upd_flags  = 1'b1;
                end
                4'b0100: begin
                    do_wb    = 1'b1;
                    wb_value = imm9_sx;
                end
                4'b0011: begin
                    alu_opcode  = op;
                    alu_a       = pc_q;
                    alu_b       = imm9_sx;
                    // cond mask is {Z,P,N}; N means neither zero nor positive
                    do_redirect = |(rd & {flag_z, flag_p, ~flag_z & ~flag_p});
                end
                4'b0010: begin
                    alu_opcode  = op;
                    alu_a       = regs[rs];
                    alu_b       = imm6_sx;
                    do_redirect = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            instr_q        <= '0;
            pc_q           <= '0;
            alu_z_q        <= 1'b0;
            alu_p_q        <= 1'b0;
            upd_flags_q    <= 1'b0;
            flag_z         <= 1'b1;
            flag_p         <= 1'b0;
            wb_valid       <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state <= state_n;
            if (instr_valid && instr_ready) begin
                instr_q <= instr;
                pc_q    <= instr_pc;
            end
            if (state == S_EXEC) begin
                alu_z_q     <= alu_zero;
                alu_p_q     <= alu_positive;
                upd_flags_q <= upd_flags;
            end
            // commit outputs are registered out of EXEC, so they are live only in COMMIT
            wb_valid       <= do_wb;
            wb_rd          <= do_wb ? rd : 3'd0;
            wb_data        <= do_wb ? wb_value : '0;
            redirect_valid <= do_redirect;
            redirect_pc    <= do_redirect ? alu_result : '0;
            if (state == S_COMMIT) begin
                if (wb_valid) regs[wb_rd] <= wb_data;
                if (upd_flags_q) begin
                    flag_z <= alu_z_q;
                    flag_p <= alu_p_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// tb/tb_exec_ctrl.sv - self-checking bench for exec_ctrl with a behavioural ALU and reference model
module tb_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic [11:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_zero, alu_positive;
    logic        flag_z, flag_p;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [11:0] wb_data;
    logic        redirect_valid;
    logic [11:0] redirect_pc;

    always #5 clk = ~clk;

    exec_ctrl #(.NREGS(8), .WIDTH(12)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_positive(alu_positive),
        .flag_z(flag_z), .flag_p(flag_p),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // external combinational ALU
    logic signed [11:0] alu_sa;
    assign alu_sa = alu_a;
    always_comb begin
        case (alu_opcode)
            4'h8:    alu_result = alu_b + alu_a;
            4'h9:    alu_result = alu_b - alu_a;
            4'hA:    alu_result = alu_a & alu_b;
            4'hB:    alu_result = alu_a | alu_b;
            4'hC:    alu_result = alu_a ^ alu_b;
            4'hD:    alu_result = alu_a << alu_b;
            4'hE:    alu_result = alu_a >> alu_b;
            4'hF:    alu_result = 12'(alu_sa >>> alu_b);
            4'h5:    alu_result = ~alu_b;
            4'h2,
            4'h3:    alu_result = alu_a + alu_b;
            default: alu_result = 12'h000;
        endcase
        alu_zero     = (alu_result == 12'h000);
        alu_positive = !alu_result[11] && (alu_result != 12'h000);
    end

    int total = 0;
    int bad = 0;

    logic [11:0] m_r [8];
    logic        m_z, m_p;
    logic [11:0] last_wb_data, last_redirect_pc;
    logic        last_wb_valid, last_redirect_valid;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 12'h000;
        m_z = 1'b1;
        m_p = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins, input logic [11:0] pc);
        logic [3:0]  op;
        logic [2:0]  rd, rs;
        logic [11:0] ra, rb, s9, s6, res, e_a, e_b, tgt;
        logic [3:0]  e_op;
        logic        e_wb, e_rv, e_upd, n;
        op = ins[15:12]; rd = ins[11:9]; rs = ins[8:6];
        s9 = {{3{ins[8]}}, ins[8:0]};
        s6 = {{6{ins[5]}}, ins[5:0]};
        ra = m_r[rs]; rb = m_r[rd];
        e_op = 4'h0; e_a = 12'h000; e_b = 12'h000; res = 12'h000; tgt = 12'h000;
        e_wb = 1'b0; e_rv = 1'b0; e_upd = 1'b0;
        if (op >= 4'h8 || op == 4'h5) begin
            e_op = op; e_a = ra; e_b = rb; e_wb = 1'b1; e_upd = 1'b1;
            case (op)
                4'h8: res = rb + ra;
                4'h9: res = rb - ra;
                4'hA: res = rb & ra;
                4'hB: res = rb | ra;
                4'hC: res = rb ^ ra;
                4'hD: res = (rb >= 12) ? 12'h000 : 12'(ra << rb[3:0]);
                4'hE: res = (rb >= 12) ? 12'h000 : ra >> rb[3:0];
                4'hF: res = (rb >= 12) ? {12{ra[11]}} : 12'($signed(ra) >>> rb[3:0]);
                default: res = ~rb;
            endcase
        end else if (op == 4'h4) begin
            e_wb = 1'b1; res = s9;
        end else if (op == 4'h3) begin
            e_op = op; e_a = pc; e_b = s9; tgt = pc + s9;
            n = !m_z && !m_p;
            e_rv = (ins[11] && m_z) || (ins[10] && m_p) || (ins[9] && n);
        end else if (op == 4'h2) begin
            e_op = op; e_a = ra; e_b = s6; tgt = ra + s6; e_rv = 1'b1;
        end

        for (int k = 0; k < 20 && !instr_ready; k++) @(negedge clk);
        chk("ready_wait", instr_ready, 1);
        instr_valid = 1'b1; instr = ins; instr_pc = pc;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0; instr = 16'($urandom); instr_pc = 12'($urandom);
        chk("exec_opcode", alu_opcode, e_op);
        chk("exec_alu_a", alu_a, e_a);
        chk("exec_alu_b", alu_b, e_b);
        chk("exec_ready", instr_ready, 0);
        chk("exec_wb_valid", wb_valid, 0);
        @(negedge clk);
        last_wb_valid = wb_valid; last_wb_data = wb_data;
        last_redirect_valid = redirect_valid; last_redirect_pc = redirect_pc;
        chk("commit_wb_valid", wb_valid, e_wb);
        chk("commit_redirect_valid", redirect_valid, e_rv);
        if (e_wb) begin
            chk("commit_wb_rd", wb_rd, rd);
            chk("commit_wb_data", wb_data, res);
        end
        if (e_rv) chk("commit_redirect_pc", redirect_pc, tgt);
        if (e_wb) m_r[rd] = res;
        if (e_upd) begin
            m_z = (res == 12'h000);
            m_p = !res[11] && (res != 12'h000);
        end
        @(negedge clk);
        chk("after_flag_z", flag_z, m_z);
        chk("after_flag_p", flag_p, m_p);
        chk("after_ready", instr_ready, 1);
        chk("after_wb_valid", wb_valid, 0);
        chk("after_redirect_valid", redirect_valid, 0);
    endtask

    initial begin
        int cnt;
        logic [15:0] ins;
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000; instr_pc = 12'h000;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", instr_ready, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", instr_ready, 1);
        chk("idle_flag_z", flag_z, 1);
        chk("idle_flag_p", flag_p, 0);
        for (int i = 0; i < 3; i++) begin
            chk("idle_wb_valid", wb_valid, 0);
            chk("idle_redirect_valid", redirect_valid, 0);
            @(negedge clk);
        end

        issue({4'h4, 3'd1, 9'd5}, 12'h100);
        issue({4'h4, 3'd2, 9'd3}, 12'h101);
        issue({4'h9, 3'd2, 3'd1, 6'd0}, 12'h102);
        chk("sub_wb_data", last_wb_data, 12'hFFE);
        chk("sub_flag_z", flag_z, 0);
        chk("sub_flag_p", flag_p, 0);
        issue({4'h3, 3'b001, 9'h1FC}, 12'h010);
        chk("br_n_taken", last_redirect_valid, 1);
        chk("br_n_pc", last_redirect_pc, 12'h00C);
        issue({4'h3, 3'b100, 9'h1FC}, 12'h010);
        chk("br_z_not_taken", last_redirect_valid, 0);

        issue({4'h4, 3'd1, 9'd1}, 12'h200);
        issue({4'h4, 3'd2, 9'd11}, 12'h201);
        issue({4'hD, 3'd2, 3'd1, 6'd0}, 12'h202);
        chk("sl_wb_data", last_wb_data, 12'h800);
        issue({4'h8, 3'd2, 3'd2, 6'd0}, 12'h203);
        chk("add_wrap_wb_data", last_wb_data, 12'h000);
        chk("add_wrap_flag_z", flag_z, 1);

        issue({4'h4, 3'd3, 9'h040}, 12'h300);
        issue({4'h2, 3'd0, 3'd3, 6'd2}, 12'h301);
        chk("jmp_pc", last_redirect_pc, 12'h042);
        chk("jmp_no_wb", last_wb_valid, 0);

        // reset while an ADD sits in EXEC
        for (int k = 0; k < 20 && !instr_ready; k++) @(negedge clk);
        instr_valid = 1'b1; instr = {4'h8, 3'd1, 3'd1, 6'd0}; instr_pc = 12'h400;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("midrst_in_exec", alu_opcode, 4'h8);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_wb_valid", wb_valid, 0);
        chk("midrst_redirect_valid", redirect_valid, 0);
        chk("midrst_ready_low", instr_ready, 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_ready_after", instr_ready, 1);
        chk("midrst_wb_valid_after", wb_valid, 0);
        chk("midrst_flag_z", flag_z, 1);
        for (int i = 0; i < 8; i++) issue({4'h2, 3'd0, 3'(i), 6'd0}, 12'h500);

        // held-high valid: accepted only in IDLE cycles
        instr = 16'h0000; instr_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            if (instr_valid && instr_ready) cnt++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("hold_handshakes", 16'(cnt), 3);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 80; i++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ins[15:12] = 4'h4;
            issue(ins, 12'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
